// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a 4-bit ALU; one operation in flight,
// result held in RESP until the consumer takes it.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_opa,
  input  logic [3:0] req0_opb,
  input  logic [2:0] req0_code,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_opa,
  input  logic [3:0] req1_opb,
  input  logic [2:0] req1_code,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  input  logic       rsp_ready,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_q;
  logic       id_q;
  logic [3:0] opa_q, opb_q, res_q, alu_res;
  logic [2:0] code_q;
  logic [7:0] cnt_q;
  logic       gnt_id, hs;

  // Tie goes to whoever did not win last time; otherwise the lone requester.
  always_comb begin
    gnt_id     = req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
    req1_ready = (state_q == IDLE) && req1_valid &&  gnt_id;
    hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  always_comb begin
    alu_res = 4'h0;
    case (code_q)
      3'b000: alu_res = opa_q + opb_q;
      3'b001: alu_res = opa_q - opb_q;
      3'b010: alu_res = ~opa_q;
      3'b011: alu_res = opa_q & opb_q;
      3'b100: alu_res = opa_q | opb_q;
      3'b101: alu_res = opa_q ^ opb_q;
      3'b110: alu_res = {3'b000, (opa_q < opb_q)};
      3'b111: alu_res = {3'b000, (opa_q == opb_q)};
      default: alu_res = 4'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      opa_q   <= 4'h0;
      opb_q   <= 4'h0;
      code_q  <= 3'b000;
      res_q   <= 4'h0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (hs) begin
        opa_q  <= gnt_id ? req1_opa  : req0_opa;
        opb_q  <= gnt_id ? req1_opb  : req0_opb;
        code_q <= gnt_id ? req1_code : req0_code;
        id_q   <= gnt_id;
        last_q <= gnt_id;
      end
      if (state_q == EXEC) res_q <= alu_res;
      if (state_q == RESP && rsp_ready) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter against a spec-level reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [2:0] req0_code, req1_code;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [3:0] rsp_res;
  logic [7:0] done_cnt;

  int checks = 0;
  int errors = 0;
  int last_m = 1;
  int done_m = 0;
  int order[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opa(req1_opa), .req1_opb(req1_opb),
    .req1_code(req1_code), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_ready(rsp_ready), .done_cnt(done_cnt)
  );

  function automatic int ref_alu(input int a, input int b, input int c);
    case (c)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return 15 - a;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a < b) ? 1 : 0;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; inputs stay asserted through EXEC/RESP to prove nothing else is accepted.
  task automatic txn(input bit v0, input bit v1,
                     input int a0, input int b0, input int c0,
                     input int a1, input int b1, input int c1,
                     input int hold);
    int g, exp;
    g = (v0 && v1) ? 1 - last_m : (v1 ? 1 : 0);
    req0_valid = v0; req0_opa = 4'(a0); req0_opb = 4'(b0); req0_code = 3'(c0);
    req1_valid = v1; req1_opa = 4'(a1); req1_opb = 4'(b1); req1_code = 3'(c1);
    rsp_ready  = (hold == 0);
    #1;
    chk("idle_rdy0", int'(req0_ready), (g == 0) ? 1 : 0);
    chk("idle_rdy1", int'(req1_ready), (g == 1) ? 1 : 0);
    chk("idle_vld", int'(rsp_valid), 0);
    @(posedge clk); #1;
    last_m = g;
    order.push_back(g);
    exp = g ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
    req0_opa = ~req0_opa; req1_opb = ~req1_opb;
    chk("exec_vld", int'(rsp_valid), 0);
    chk("exec_rdy", int'(req0_ready) + int'(req1_ready), 0);
    chk("exec_cnt", int'(done_cnt), done_m);
    @(posedge clk); #1;
    chk("resp_vld", int'(rsp_valid), 1);
    chk("resp_id", int'(rsp_id), g);
    chk("resp_res", int'(rsp_res), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", int'(rsp_valid), 1);
      chk("hold_id", int'(rsp_id), g);
      chk("hold_res", int'(rsp_res), exp);
      chk("hold_rdy", int'(req0_ready) + int'(req1_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    done_m = (done_m + 1) % 256;
    chk("post_vld", int'(rsp_valid), 0);
    chk("post_cnt", int'(done_cnt), done_m);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_opa = 0; req0_opb = 0; req0_code = 0;
    req1_opa = 0; req1_opb = 0; req1_code = 0;
    #2;
    chk("rst_vld", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_res", int'(rsp_res), 0);
    chk("rst_cnt", int'(done_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // req0 add wraps: 9+8 = 1
    txn(1, 0, 9, 8, 0, 0, 0, 0, 0);
    chk("add_res_const", int'(rsp_res), 1);
    // req1 subtract, consumer stalls 5 cycles: 2-5 = D
    txn(0, 1, 0, 0, 0, 2, 5, 1, 5);
    chk("sub_res_const", int'(rsp_res), 13);
    txn(1, 0, 3, 3, 2, 0, 0, 0, 0);
    chk("not_const", int'(rsp_res), 12);
    txn(1, 0, 3, 3, 6, 0, 0, 0, 1);
    chk("lt_const", int'(rsp_res), 0);
    txn(1, 0, 3, 3, 7, 0, 0, 0, 0);
    chk("eq_const", int'(rsp_res), 1);

    // Reset asserted between edges while in EXEC
    req0_valid = 1; req1_valid = 1; rsp_ready = 0;
    @(posedge clk); #1;
    chk("pre_rst_exec", int'(rsp_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(rsp_valid), 0);
    chk("arst_id", int'(rsp_id), 0);
    chk("arst_res", int'(rsp_res), 0);
    chk("arst_cnt", int'(done_cnt), 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_m = 0; last_m = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_ghost_rsp", int'(rsp_valid), 0);
    end

    // Ties every transaction: strict alternation starting at requester 0
    order.delete();
    for (int i = 0; i < 6; i++)
      txn(1, 1, $urandom_range(15), $urandom_range(15), $urandom_range(7),
                $urandom_range(15), $urandom_range(15), $urandom_range(7), 0);
    for (int i = 0; i < 6; i++) chk("rr_order", order[i], i % 2);

    // Random traffic; 6 done so far, 250 more lands exactly on the wrap
    for (int i = 0; i < 250; i++) begin
      int v;
      v = $urandom_range(1, 3);
      txn(v[0], v[1], $urandom_range(15), $urandom_range(15), $urandom_range(7),
                      $urandom_range(15), $urandom_range(15), $urandom_range(7),
                      $urandom_range(2));
    end
    chk("cnt_wrap", int'(done_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
